// File: rtl/addr_sequencer.sv
// Address-register sequencer: arbitrates the memory port between instruction fetch and
// single/multi-word data access. Define ADDR_SEQ_ROUND_ROBIN_EN for round-robin arbitration.
module addr_sequencer #(
   parameter int ADDR_SEL_W = 2,
   parameter int CNT_W      = 5,
   parameter int IDX_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_req,
   input  logic                  data_req,
   input  logic [CNT_W-1:0]      data_count,
   input  logic                  data_write,
   input  logic                  mem_ready,
   output logic [ADDR_SEL_W-1:0] addr_select,
   output logic                  inc_load,
   output logic                  mem_req,
   output logic                  mem_write,
   output logic                  fetch_done,
   output logic                  data_beat,
   output logic                  data_done,
   output logic [IDX_W-1:0]      beat_index,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA_FIRST, DATA_BURST} state_t;

   localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(1 << (CNT_W - 1));
   localparam logic [ADDR_SEL_W-1:0] SEL_ALU = ADDR_SEL_W'(0);
   localparam logic [ADDR_SEL_W-1:0] SEL_PC  = ADDR_SEL_W'(1);
   localparam logic [ADDR_SEL_W-1:0] SEL_INC = ADDR_SEL_W'(2);

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] count_clamped;
   logic             in_data;
   logic             arb_point;
   logic             grant_data;

   assign busy       = (state != IDLE);
   assign mem_req    = busy;
   assign in_data    = (state == DATA_FIRST) || (state == DATA_BURST);
   assign fetch_done = (state == FETCH) && mem_ready;
   assign data_beat  = in_data && mem_ready;
   assign data_done  = data_beat && (remaining == CNT_W'(1));
   assign inc_load   = busy && mem_ready;
   // Re-arbitrate on the completing beat so back-to-back transfers carry no idle bubble.
   assign arb_point  = (state == IDLE) || fetch_done || data_done;

`ifdef ADDR_SEQ_ROUND_ROBIN_EN
   logic last_grant;  // 1 = data was granted last, 0 = fetch

   assign grant_data = data_req && (!fetch_req || !last_grant);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= 1'b0;
      else if (arb_point && grant_data)
         last_grant <= 1'b1;
      else if (arb_point && fetch_req)
         last_grant <= 1'b0;
   end
`else
   assign grant_data = data_req;
`endif

   always_comb begin
      count_clamped = data_count;
      if (data_count == '0)
         count_clamped = CNT_W'(1);
      else if (data_count > MAX_CNT)
         count_clamped = MAX_CNT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         addr_select <= SEL_PC;
         mem_write   <= 1'b0;
         beat_index  <= '0;
         remaining   <= '0;
      end else if (arb_point) begin
         if (grant_data) begin
            state       <= DATA_FIRST;
            addr_select <= SEL_ALU;
            mem_write   <= data_write;
            beat_index  <= '0;
            remaining   <= count_clamped;
         end else if (fetch_req) begin
            state       <= FETCH;
            addr_select <= SEL_PC;
            mem_write   <= 1'b0;
         end else begin
            state       <= IDLE;
            addr_select <= SEL_PC;
            mem_write   <= 1'b0;
         end
      end else if (data_beat) begin
         // Non-final data word: later words come from the incrementer bus.
         state       <= DATA_BURST;
         addr_select <= SEL_INC;
         remaining   <= remaining - CNT_W'(1);
         if (beat_index != '1)
            beat_index <= beat_index + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed bench for addr_sequencer: reset, fetch wait states, bursts, clamping,
// mid-burst reset, contention and back-to-back fetches.
module tb_addr_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       fetch_req, data_req, data_write, mem_ready;
   logic [4:0] data_count;
   logic [1:0] addr_select;
   logic       inc_load, mem_req, mem_write, fetch_done, data_beat, data_done, busy;
   logic [3:0] beat_index;

   int checks = 0;
   int errors = 0;
   logic [12:0] obs, e;

   addr_sequencer dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .data_req(data_req),
      .data_count(data_count), .data_write(data_write), .mem_ready(mem_ready),
      .addr_select(addr_select), .inc_load(inc_load), .mem_req(mem_req),
      .mem_write(mem_write), .fetch_done(fetch_done), .data_beat(data_beat),
      .data_done(data_done), .beat_index(beat_index), .busy(busy)
   );

   always #5 clk = ~clk;

   // {busy, mem_req, addr_select, mem_write, inc_load, fetch_done, data_beat, data_done, beat_index}
   assign obs = {busy, mem_req, addr_select, mem_write, inc_load, fetch_done,
                 data_beat, data_done, beat_index};

   function automatic logic [12:0] ex(input logic b, input logic [1:0] s, input logic mw,
                                      input logic il, input logic fd, input logic db,
                                      input logic dd, input logic [3:0] ix);
      return {b, b, s, mw, il, fd, db, dd, ix};
   endfunction

   task automatic test_reset;
      rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_count = 5'd0;
      data_write = 1'b0; mem_ready = 1'b0;
      @(negedge clk); #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs !== e) begin errors++; $display("FAIL reset got %h exp %h", obs, e); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_fetch_wait;
      @(negedge clk); fetch_req = 1'b1; mem_ready = 1'b0; #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL fetch_idle got %h exp %h", obs, e); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         e = ex(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
         checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL fetch_wait%0d got %h exp %h", i, obs, e); end
      end
      @(negedge clk); mem_ready = 1'b1; #1;
      e = ex(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL fetch_done got %h exp %h", obs, e); end
      fetch_req = 1'b0;
      @(negedge clk); mem_ready = 1'b0; #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL fetch_after got %h exp %h", obs, e); end
   endtask

   task automatic test_data_burst;
      @(negedge clk); data_req = 1'b1; data_count = 5'd3; data_write = 1'b1; mem_ready = 1'b1; #1;
      @(negedge clk); data_count = 5'd7; data_write = 1'b0; #1;  // post-grant changes must be ignored
      e = ex(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      checks++; if (obs !== e) begin errors++; $display("FAIL burst_b0 got %h exp %h", obs, e); end
      @(negedge clk); mem_ready = 1'b0; #1;
      e = ex(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
      checks++; if (obs !== e) begin errors++; $display("FAIL burst_wait got %h exp %h", obs, e); end
      @(negedge clk); mem_ready = 1'b1; #1;
      e = ex(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
      checks++; if (obs !== e) begin errors++; $display("FAIL burst_b1 got %h exp %h", obs, e); end
      @(negedge clk); #1;
      e = ex(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
      checks++; if (obs !== e) begin errors++; $display("FAIL burst_b2 got %h exp %h", obs, e); end
      data_req = 1'b0;
      @(negedge clk); #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL burst_after got %h exp %h", obs, e); end
   endtask

   task automatic test_count_zero;
      @(negedge clk); data_req = 1'b1; data_count = 5'd0; data_write = 1'b0; mem_ready = 1'b1; #1;
      @(negedge clk); #1;
      e = ex(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
      checks++; if (obs !== e) begin errors++; $display("FAIL count0 got %h exp %h", obs, e); end
      data_req = 1'b0;
      @(negedge clk); #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL count0_after got %h exp %h", obs, e); end
   endtask

   task automatic test_clamp;
      @(negedge clk); data_req = 1'b1; data_count = 5'd20; data_write = 1'b0; mem_ready = 1'b1; #1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); #1;
         e = ex(1'b1, (i == 0) ? 2'b00 : 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, (i == 15), 4'(i));
         checks++; if (obs !== e) begin errors++; $display("FAIL clamp_b%0d got %h exp %h", i, obs, e); end
      end
      data_req = 1'b0;
      @(negedge clk); #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL clamp_after got %h exp %h", obs, e); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk); data_req = 1'b1; data_count = 5'd16; data_write = 1'b0; mem_ready = 1'b1; #1;
      for (int i = 0; i < 6; i++) @(negedge clk);
      #1;
      e = ex(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5);
      checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_b5 got %h exp %h", obs, e); end
      rst = 1'b1; data_req = 1'b0; #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_reset got %h exp %h", obs, e); end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_idle%0d got %h exp %h", i, obs, e); end
      end
   endtask

   task automatic test_contention;
`ifdef ADDR_SEQ_ROUND_ROBIN_EN
      @(negedge clk); data_req = 1'b1; fetch_req = 1'b1; data_count = 5'd1; data_write = 1'b0; mem_ready = 1'b1; #1;
      @(negedge clk); #1;
      e = ex(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
      checks++; if (obs !== e) begin errors++; $display("FAIL rr_data got %h exp %h", obs, e); end
      @(negedge clk); #1;
      e = ex(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL rr_fetch got %h exp %h", obs, e); end
      data_req = 1'b0; fetch_req = 1'b0;
`else
      @(negedge clk); data_req = 1'b1; fetch_req = 1'b1; data_count = 5'd2; data_write = 1'b1; mem_ready = 1'b1; #1;
      @(negedge clk); #1;
      e = ex(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      checks++; if (obs !== e) begin errors++; $display("FAIL pri_b0 got %h exp %h", obs, e); end
      @(negedge clk); #1;
      e = ex(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1);
      checks++; if (obs !== e) begin errors++; $display("FAIL pri_b1 got %h exp %h", obs, e); end
      data_req = 1'b0;
      @(negedge clk); #1;
      e = ex(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL pri_fetch got %h exp %h", obs, e); end
      fetch_req = 1'b0;
`endif
      @(negedge clk); #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL contend_after got %h exp %h", obs, e); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk); fetch_req = 1'b1; mem_ready = 1'b1; #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         e = ex(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
         checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL b2b_f%0d got %h exp %h", i, obs, e); end
      end
      fetch_req = 1'b0;
      @(negedge clk); #1;
      e = ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++; if (obs[12:4] !== e[12:4]) begin errors++; $display("FAIL b2b_after got %h exp %h", obs, e); end
   endtask

   initial begin
      test_reset;
      test_fetch_wait;
      test_data_burst;
      test_count_zero;
      test_clamp;
      test_reset_mid;
      test_contention;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
